// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Tracks the E, M and W stage occupancy, selects operand forwarding for the
// instruction in E, and resolves traps, data-memory waits, taken branches and
// load-use dependencies into stall/flush requests for the front end.
module pipeline_hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int CNT_W    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rs1_D,
   input  logic [REG_W-1:0] rs2_D,
   input  logic             useRs1_D,
   input  logic             useRs2_D,
   input  logic [REG_W-1:0] rd_D,
   input  logic             regWrite_D,
   input  logic             memRead_D,
   input  logic             memWrite_D,
   input  logic             valid_D,
   input  logic             branchTaken_E,
   input  logic             trapTrigger,
   input  logic             trapReturn,
   input  logic             dmReady_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic             valid_E,
   output logic             valid_M,
   output logic             valid_W,
   output logic [REG_W-1:0] rd_W,
   output logic             regWrite_W,
   output logic [CNT_W-1:0] stallCount
);

   // Per-stage bookkeeping for E and M; memory operations have completed by
   // W, so the writeback stage only keeps what the register file needs.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
   } stage_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
   } wb_t;

   // Highest-priority event active this cycle; only one ever takes effect.
   typedef enum logic [2:0] {
      EV_NONE,
      EV_TRAP,
      EV_MEM_STALL,
      EV_BRANCH,
      EV_LOAD_USE
   } event_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   stage_t           e_q, e_next;
   stage_t           m_q, m_next;
   wb_t              w_q, w_next;
   logic [REG_W-1:0] rs1_e_q, rs1_e_next;
   logic [REG_W-1:0] rs2_e_q, rs2_e_next;
   logic [CNT_W-1:0] stall_count_q;

   event_e           ev;
   logic             trap;
   logic             mem_stall;
   logic             branch;
   logic             load_use;

   // A destination can be a hazard source unless it is the hardwired zero register.
   function automatic logic rd_qualifies(input logic [REG_W-1:0] rd);
      return (rd != '0) || (ZERO_REG == 0);
   endfunction

   // A stage produces source src when it will write that register.
   function automatic logic stage_hit(input logic             valid,
                                      input logic             reg_write,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] src);
      return valid && reg_write && (rd == src) && rd_qualifies(rd);
   endfunction

   // Forward from M unless M is a load whose data is not yet available,
   // otherwise from W, otherwise read the register file.
   function automatic logic [1:0] fwd_sel(input stage_t           m,
                                          input wb_t              w,
                                          input logic [REG_W-1:0] src);
      if (stage_hit(m.valid, m.reg_write, m.rd, src) && !m.mem_read) return FWD_M;
      if (stage_hit(w.valid, w.reg_write, w.rd, src))                return FWD_W;
      return FWD_RF;
   endfunction

   assign trap      = trapTrigger | trapReturn;
   assign mem_stall = m_q.valid && (m_q.mem_read || m_q.mem_write) && !dmReady_M;
   assign branch    = branchTaken_E && e_q.valid;
   assign load_use  = valid_D && e_q.valid && e_q.mem_read && rd_qualifies(e_q.rd) &&
                      ((useRs1_D && (rs1_D == e_q.rd)) || (useRs2_D && (rs2_D == e_q.rd)));

   // Event arbitration: trap > memory wait > branch > load-use.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ev = EV_NONE;
      if (trap)           ev = EV_TRAP;
      else if (mem_stall) ev = EV_MEM_STALL;
      else if (branch)    ev = EV_BRANCH;
      else if (load_use)  ev = EV_LOAD_USE;
   end

   // Front-end control and forwarding, forced quiet while reset is held.
   always_comb begin
      stall_F = 1'b0;
      flush_D = 1'b0;
      fwdA_E  = FWD_RF;
      fwdB_E  = FWD_RF;
      if (!reset) begin
         case (ev)
            EV_TRAP, EV_BRANCH:        flush_D = 1'b1;
            EV_MEM_STALL, EV_LOAD_USE: stall_F = 1'b1;
            default: ;
         endcase
         fwdA_E = fwd_sel(m_q, w_q, rs1_e_q);
         fwdB_E = fwd_sel(m_q, w_q, rs2_e_q);
      end
   end

   assign stall_D = stall_F;

   // Next stage contents: normal advance, then the winning event overrides it.
   always_comb begin
      e_next.valid     = valid_D;
      e_next.rd        = rd_D;
      e_next.reg_write = regWrite_D & valid_D;
      e_next.mem_read  = memRead_D  & valid_D;
      e_next.mem_write = memWrite_D & valid_D;
      rs1_e_next       = rs1_D;
      rs2_e_next       = rs2_D;
      m_next           = e_q;
      w_next.valid     = m_q.valid;
      w_next.rd        = m_q.rd;
      w_next.reg_write = m_q.reg_write;
      case (ev)
         EV_TRAP: begin
            // W still retires the oldest instruction; everything younger is squashed.
            e_next = '0;
            m_next = '0;
         end
         EV_MEM_STALL: begin
            // E and M freeze until memory answers; W receives a bubble.
            e_next     = e_q;
            rs1_e_next = rs1_e_q;
            rs2_e_next = rs2_e_q;
            m_next     = m_q;
            w_next     = '0;
         end
         EV_BRANCH, EV_LOAD_USE: e_next = '0;
         default: ;
      endcase
   end

   // Stage registers and the saturating stall-cycle counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         e_q           <= '0;
         m_q           <= '0;
         w_q           <= '0;
         rs1_e_q       <= '0;
         rs2_e_q       <= '0;
         stall_count_q <= '0;
      end else begin
         e_q     <= e_next;
         m_q     <= m_next;
         w_q     <= w_next;
         rs1_e_q <= rs1_e_next;
         rs2_e_q <= rs2_e_next;
         if (stall_F && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
      end
   end

   assign valid_E    = e_q.valid;
   assign valid_M    = m_q.valid;
   assign valid_W    = w_q.valid;
   assign rd_W       = w_q.rd;
   assign regWrite_W = w_q.valid & w_q.reg_write;
   assign stallCount = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver applies one directed
// vector per cycle and queues the hand-computed expected outputs; a monitor on
// the falling edge pops each entry and compares it with what the DUT shows.
module tb_pipeline_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 4;
   localparam int X     = -1;  // field not compared for this vector

   logic             clk;
   logic             reset;
   logic [REG_W-1:0] rs1_D, rs2_D, rd_D;
   logic             useRs1_D, useRs2_D;
   logic             regWrite_D, memRead_D, memWrite_D, valid_D;
   logic             branchTaken_E, trapTrigger, trapReturn, dmReady_M;
   logic             stall_F, stall_D, flush_D;
   logic [1:0]       fwdA_E, fwdB_E;
   logic             valid_E, valid_M, valid_W;
   logic [REG_W-1:0] rd_W;
   logic             regWrite_W;
   logic [CNT_W-1:0] stallCount;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .useRs1_D(useRs1_D), .useRs2_D(useRs2_D),
      .rd_D(rd_D), .regWrite_D(regWrite_D), .memRead_D(memRead_D),
      .memWrite_D(memWrite_D), .valid_D(valid_D),
      .branchTaken_E(branchTaken_E), .trapTrigger(trapTrigger),
      .trapReturn(trapReturn), .dmReady_M(dmReady_M),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
      .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
      .valid_E(valid_E), .valid_M(valid_M), .valid_W(valid_W),
      .rd_W(rd_W), .regWrite_W(regWrite_W), .stallCount(stallCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string name;
      int    stall;
      int    flush;
      int    fwd_a;
      int    fwd_b;
      int    v_e;
      int    v_m;
      int    v_w;
      int    rd_w;
      int    rw_w;
      int    cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_x;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      if (exp != X) begin
         n_checks++;
         if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
         end
      end
   endtask

   function automatic exp_t ex(input string n, input int st, input int fl,
                               input int fa, input int fb, input int ve,
                               input int vm, input int vw, input int rdw,
                               input int rww, input int cnt);
      exp_t x;
      x.name = n;  x.stall = st; x.flush = fl; x.fwd_a = fa; x.fwd_b = fb;
      x.v_e  = ve; x.v_m   = vm; x.v_w   = vw; x.rd_w  = rdw; x.rw_w = rww;
      x.cnt  = cnt;
      return x;
   endfunction

   // Monitor: compare the oldest queued expectation once per cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_x = sb_q.pop_front();
         check({mon_x.name, ".stall_F"},    int'(stall_F),    mon_x.stall);
         check({mon_x.name, ".stall_D"},    int'(stall_D),    mon_x.stall);
         check({mon_x.name, ".flush_D"},    int'(flush_D),    mon_x.flush);
         check({mon_x.name, ".fwdA_E"},     int'(fwdA_E),     mon_x.fwd_a);
         check({mon_x.name, ".fwdB_E"},     int'(fwdB_E),     mon_x.fwd_b);
         check({mon_x.name, ".valid_E"},    int'(valid_E),    mon_x.v_e);
         check({mon_x.name, ".valid_M"},    int'(valid_M),    mon_x.v_m);
         check({mon_x.name, ".valid_W"},    int'(valid_W),    mon_x.v_w);
         check({mon_x.name, ".rd_W"},       int'(rd_W),       mon_x.rd_w);
         check({mon_x.name, ".regWrite_W"}, int'(regWrite_W), mon_x.rw_w);
         check({mon_x.name, ".stallCount"}, int'(stallCount), mon_x.cnt);
      end
   end

   task automatic idle();
      valid_D = 1'b0; rs1_D = '0; rs2_D = '0; useRs1_D = 1'b0; useRs2_D = 1'b0;
      rd_D = '0; regWrite_D = 1'b0; memRead_D = 1'b0; memWrite_D = 1'b0;
      branchTaken_E = 1'b0; trapTrigger = 1'b0; trapReturn = 1'b0; dmReady_M = 1'b1;
   endtask

   task automatic dec(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                      input logic u1, input logic [REG_W-1:0] rs2, input logic u2,
                      input logic rw, input logic mr);
      valid_D = 1'b1; rd_D = rd; rs1_D = rs1; useRs1_D = u1; rs2_D = rs2;
      useRs2_D = u2; regWrite_D = rw; memRead_D = mr; memWrite_D = 1'b0;
   endtask

   // Queue the expectation for the vector now on the inputs, then advance a cycle.
   task automatic step(input exp_t x);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset overrides pending trap, branch and memory-wait requests.
      trapTrigger = 1'b1; branchTaken_E = 1'b1; dmReady_M = 1'b0;
      step(ex("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(ex("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;

      // ALU back-to-back forwarding from M, then from W.
      idle(); dec(5, 1, 1, 2, 1, 1, 0); step(ex("alu_x5",  0, 0, 0, 0, 0, 0, 0, X, X, 0));
      idle(); dec(6, 5, 1, 3, 1, 1, 0); step(ex("dep_x6",  0, 0, 0, 0, 1, 0, 0, X, X, 0));
      idle(); dec(8, 5, 1, 6, 1, 1, 0); step(ex("fwd_m",   0, 0, 2, 0, 1, 1, 0, X, X, 0));
      idle();                           step(ex("fwd_w",   0, 0, 1, 2, 1, 1, 1, 5, 1, 0));
      idle();                           step(ex("drain1",  0, 0, 0, 0, 0, 1, 1, 6, 1, 0));
      idle();                           step(ex("drain2",  X, X, X, X, 0, 0, 1, 8, 1, 0));

      // Load-use: one stall cycle, a bubble in E, then forwarding from W.
      idle(); dec(7, 2, 1, 0, 0, 1, 1); step(ex("lw_x7",   0, 0, 0, 0, 0, 0, 0, X, X, 0));
      idle(); dec(9, 7, 1, 3, 1, 1, 0); step(ex("lu_stall",1, 0, 0, 0, 1, 0, 0, X, X, 0));
      idle(); dec(9, 7, 1, 3, 1, 1, 0); step(ex("lu_bub",  0, 0, 0, 0, 0, 1, 0, X, X, 1));
      idle();                           step(ex("lu_fwd",  0, 0, 1, 0, 1, 0, 1, 7, 1, 1));

      // Data memory wait of three cycles on a load in M.
      idle(); dec(10, 1, 1, 0, 0, 1, 1); step(ex("lw_x10", 0, 0, 0, 0, 0, 1, 0, X, X, 1));
      idle();                            step(ex("lw_e",   0, 0, 0, 0, 1, 0, 1, 9, 1, 1));
      idle(); dmReady_M = 1'b0;          step(ex("mw1",    1, 0, 0, 0, 0, 1, 0, X, X, 1));
      idle(); dmReady_M = 1'b0;          step(ex("mw2",    1, 0, X, X, 0, 1, 0, X, X, 2));
      idle(); dmReady_M = 1'b0;          step(ex("mw3",    1, 0, X, X, 0, 1, 0, X, X, 3));
      idle();                            step(ex("mw_done",0, 0, X, X, 0, 1, 0, X, X, 4));
      idle();                            step(ex("mw_ret", 0, 0, X, X, 0, 0, 1, 10, 1, 4));

      // Taken branch wins over a simultaneous load-use.
      idle(); dec(11, 1, 1, 0, 0, 1, 1); step(ex("lw_x11", 0, 0, X, X, 0, 0, 0, X, X, 4));
      idle(); dec(12, 11, 1, 0, 0, 1, 0); branchTaken_E = 1'b1;
                                         step(ex("br_lu",  0, 1, X, X, 1, 0, 0, X, X, 4));
      idle();                            step(ex("br_next",0, 0, X, X, 0, 1, 0, X, X, 4));

      // Trap during a memory wait squashes E and M and releases the stall.
      idle(); dec(13, 1, 1, 0, 0, 1, 1); step(ex("lw_x13", 0, 0, X, X, 0, 0, 1, 11, 1, 4));
      idle(); dec(14, 1, 1, 2, 1, 1, 0); step(ex("add_x14",0, 0, X, X, 1, 0, 0, X, X, 4));
      idle(); dec(15, 1, 1, 0, 0, 1, 0); trapTrigger = 1'b1; dmReady_M = 1'b0;
                                         step(ex("trap_mw",0, 1, X, X, 1, 1, 0, X, X, 4));
      idle(); dmReady_M = 1'b0;          step(ex("trap_nx",0, 0, X, X, 0, 0, 1, 13, 1, 4));
      idle(); dec(16, 1, 1, 0, 0, 1, 0); trapTrigger = 1'b1; trapReturn = 1'b1;
                                         step(ex("trap_both",0, 1, X, X, 0, 0, 0, X, X, 4));
      idle();                            step(ex("trap_bnx",0, 0, X, X, 0, 0, 0, X, X, 4));

      // x0 is never a hazard source: no load-use stall, no forwarding.
      idle(); dec(0, 1, 1, 0, 0, 1, 1);  step(ex("lw_x0",  0, 0, X, X, 0, 0, 0, X, X, 4));
      idle(); dec(0, 0, 1, 0, 1, 1, 0);  step(ex("x0_lu",  0, 0, 0, 0, 1, 0, 0, X, X, 4));
      idle(); dec(3, 0, 1, 0, 1, 1, 0);  step(ex("x0_fm1", 0, 0, 0, 0, 1, 1, 0, X, X, 4));
      idle();                            step(ex("x0_fm2", 0, 0, 0, 0, 1, 1, 1, 0, 1, 4));
      idle();                            step(ex("x0_dr1", 0, 0, X, X, 0, 1, 1, 0, 1, 4));
      idle();                            step(ex("x0_dr2", 0, 0, X, X, 0, 0, 1, 3, 1, 4));

      // Long memory wait drives the counter to all-ones where it must stay.
      idle(); dec(20, 1, 1, 0, 0, 1, 1); step(ex("lw_x20", 0, 0, X, X, 0, 0, 0, X, X, 4));
      idle();                            step(ex("lw20_e", 0, 0, X, X, 1, 0, 0, X, X, 4));
      for (int i = 0; i < 14; i++) begin
         idle(); dmReady_M = 1'b0;
         step(ex($sformatf("sat%0d", i), 1, 0, X, X, 0, 1, 0, X, X,
                 (4 + i > 15) ? 15 : 4 + i));
      end

      // Reset in the middle of a memory wait plus a trap request clears everything.
      idle(); dmReady_M = 1'b0; trapTrigger = 1'b1; reset = 1'b1;
      step(ex("rst_mw",   0, 0, 0, 0, 0, 1, 0, X, X, 15));
      reset = 1'b0;
      idle(); dmReady_M = 1'b0;
      step(ex("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      idle();
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations pending, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
